store_stage: RTL and testbench

STORE_STAGE -- requirements
Module: store_stage

---
 rtl/store_stage.sv | 125 ++++++++++++
 tb/tb_store_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/store_stage.sv
// Store stage: sequences one data-memory write per request through ADDR (MAR), DATA (MDR) and WRITE phases.
// Define STORE_BUFFER_EN to place a 2-entry request FIFO in front of the sequencer.
module store_stage #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rd_wr,
  output logic              dm_en,
  output logic              busy,
  output logic [7:0]        store_count
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_WRITE} state_e;

  state_e              state_q, state_d;
  logic                start;
  logic                buf_nonempty;
  logic [ADDR_W-1:0]   src_addr;
  logic [DATA_W-1:0]   src_data;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_data_q;
  logic [ADDR_W-1:0]   dm_address_q;
  logic [DATA_W-1:0]   dm_wdata_q;
  logic [7:0]          store_count_q;

`ifdef STORE_BUFFER_EN
  logic [ADDR_W-1:0] fifo_addr_q [2];
  logic [DATA_W-1:0] fifo_data_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              push, pop;

  assign st_ready     = rst_n && (count_q != 2'd2);
  assign push         = st_valid && st_ready;
  assign pop          = (state_q == S_IDLE) && (count_q != 2'd0);
  assign start        = pop;
  assign src_addr     = fifo_addr_q[rd_ptr_q];
  assign src_data     = fifo_data_q[rd_ptr_q];
  assign buf_nonempty = (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // FIFO storage is data-only; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= st_addr;
      fifo_data_q[wr_ptr_q] <= st_data;
    end
  end
`else
  assign st_ready     = rst_n && (state_q == S_IDLE);
  assign start        = st_valid && st_ready;
  assign src_addr     = st_addr;
  assign src_data     = st_data;
  assign buf_nonempty = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADDR;
      S_ADDR:  state_d = S_DATA;
      S_DATA:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // In-flight request is frozen here so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (start) begin
      req_addr_q <= src_addr;
      req_data_q <= src_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      dm_address_q  <= '0;
      dm_wdata_q    <= '0;
      store_count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ADDR)  dm_address_q  <= req_addr_q;
      if (state_q == S_DATA)  dm_wdata_q    <= req_data_q;
      if (state_q == S_WRITE) store_count_q <= store_count_q + 8'd1;
    end
  end

  assign dm_address  = dm_address_q;
  assign dm_wdata    = dm_wdata_q;
  assign dm_en       = (state_q == S_WRITE);
  assign dm_rd_wr    = (state_q == S_WRITE);
  assign busy        = (state_q != S_IDLE) || buf_nonempty;
  assign store_count = store_count_q;

endmodule

// File: tb/tb_store_stage.sv
// Scoreboard bench for store_stage: the driver queues expected writes, a negedge monitor checks them.
module tb_store_stage;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef STORE_BUFFER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic [AW-1:0] dm_address;
  logic [DW-1:0] dm_wdata;
  logic          dm_rd_wr, dm_en, busy;
  logic [7:0]    store_count;

  store_stage #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .dm_address(dm_address),
    .dm_wdata(dm_wdata), .dm_rd_wr(dm_rd_wr), .dm_en(dm_en),
    .busy(busy), .store_count(store_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            acc;
    int            lat;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] exp_cnt = 8'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write the DUT performs must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (dm_rd_wr !== dm_en) begin
        fails++;
        $display("FAIL rd_wr_vs_en: rd_wr=%b en=%b", dm_rd_wr, dm_en);
      end
      if (dm_en === 1'b1) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", dm_address, dm_wdata);
        end else begin
          e = q.pop_front();
          check("wr_addr", 64'(dm_address), 64'(e.a));
          check("wr_data", 64'(dm_wdata), 64'(e.d));
          check("wr_count_before", 64'(store_count), 64'(exp_cnt));
          if (e.lat >= 0) check("wr_latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
          exp_cnt = exp_cnt + 8'd1;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat);
    exp_t x;
    st_valid = 1'b1; st_addr = a; st_data = d;
    for (int t = 0; t < 64 && !st_ready; t++) @(negedge clk);
    if (!st_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: st_ready=%b expected 1", st_ready);
    end else begin
      x.a = a; x.d = d; x.acc = cyc + 1; x.lat = lat;
      q.push_back(x);
      @(negedge clk);
    end
    st_valid = 1'b0; st_addr = ~a; st_data = ~d;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 200 && (busy || q.size() != 0); t++) @(negedge clk);
    check("drain_done", 64'(busy || q.size() != 0), 64'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_cnt = 8'd0;
    check("rst_st_ready", 64'(st_ready), 64'd0);
    check("rst_dm_en", 64'(dm_en), 64'd0);
    check("rst_rd_wr", 64'(dm_rd_wr), 64'd0);
    check("rst_addr", 64'(dm_address), 64'd0);
    check("rst_wdata", 64'(dm_wdata), 64'd0);
    check("rst_count", 64'(store_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_st_ready", 64'(st_ready), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Single store with latency and held outputs afterwards
    send(5'h03, 32'hDEADBEEF, LAT);
    wait_idle();
    check("single_count", 64'(store_count), 64'd1);
    check("single_addr_hold", 64'(dm_address), 64'h03);
    check("single_data_hold", 64'(dm_wdata), 64'hDEADBEEF);

`ifndef STORE_BUFFER_EN
    // Back-to-back with st_valid held: ready stays low through ADDR/DATA/WRITE
    do_reset();
    send(5'h01, 32'h1111_0001, LAT);
    st_valid = 1'b1;
    check("b2b_ready_addr", 64'(st_ready), 64'd0);
    @(negedge clk);
    check("b2b_ready_data", 64'(st_ready), 64'd0);
    @(negedge clk);
    check("b2b_ready_write", 64'(st_ready), 64'd0);
    @(negedge clk);
    check("b2b_ready_idle", 64'(st_ready), 64'd1);
    send(5'h02, 32'h2222_0002, LAT);
    send(5'h03, 32'h3333_0003, LAT);
    wait_idle();
    check("b2b_count", 64'(store_count), 64'd3);
`else
    // Four requests offered every cycle: third acceptance fills the buffer
    do_reset();
    send(5'h0A, 32'hA0A0_000A, LAT);
    send(5'h0B, 32'hB0B0_000B, -1);
    send(5'h0C, 32'hC0C0_000C, -1);
    check("full_ready_low", 64'(st_ready), 64'd0);
    send(5'h0D, 32'hD0D0_000D, -1);
    wait_idle();
    check("full_count", 64'(store_count), 64'd4);
`endif

    // Reset during DATA aborts the write
    do_reset();
    send(5'h07, 32'h0770_0770, LAT);
    @(negedge clk);
`ifdef STORE_BUFFER_EN
    @(negedge clk);
`endif
    check("mid_busy", 64'(busy), 64'd1);
    do_reset();
    repeat (6) @(negedge clk);
    check("mid_count_zero", 64'(store_count), 64'd0);
    send(5'h08, 32'h0880_0880, LAT);
    wait_idle();
    check("post_rst_count", 64'(store_count), 64'd1);
    check("post_rst_addr", 64'(dm_address), 64'h08);

    // Counter wrap
    do_reset();
    for (int i = 1; i <= 255; i++) send(AW'(i), DW'(i) * 32'h0101_0101, -1);
    wait_idle();
    check("count_255", 64'(store_count), 64'd255);
    send(5'h1F, 32'hFFFF_0000, LAT);
    wait_idle();
    check("count_wrap", 64'(store_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
